// File: rtl/uart_flow_ctrl_pkg.sv
// Shared types and helpers for the UART auto flow control sequencer.
package uart_flow_ctrl_pkg;

    // TX grant sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CTS = 2'd1,
        GRANT    = 2'd2,
        BUSY     = 2'd3
    } flow_state_e;

    // RX FIFO trigger levels selected by FCR[7:6].
    localparam int unsigned RxTrigLevels [4] = '{1, 4, 8, 14};

    // Width of the value returned by trig_level; callers resize to their level width.
    localparam int unsigned TrigW = 8;

    // Map the FCR trigger select onto an entry count.
    function automatic logic [TrigW-1:0] trig_level(input logic [1:0] sel);
        return TrigW'(RxTrigLevels[sel]);
    endfunction

endpackage

// File: rtl/uart_flow_ctrl_if.sv
// TX engine <-> flow control handshake bundle.
interface uart_flow_ctrl_if;

    logic tx_req;     // TX engine has a byte ready to start a frame
    logic tx_gnt;     // one-cycle pulse: frame may start now
    logic tx_busy;    // TX engine is shifting a frame
    logic cts_stall;  // request pending and blocked by CTS

    // TX engine side.
    modport master (
        output tx_req,
        output tx_busy,
        input  tx_gnt,
        input  cts_stall
    );

    // Flow controller side.
    modport slave (
        input  tx_req,
        input  tx_busy,
        output tx_gnt,
        output cts_stall
    );

endinterface

// File: rtl/uart_flow_ctrl_debounce.sv
// Saturating stable-high counter: CTS must be seen high for CtsStableCycles
// consecutive cycles (and still be high now) before cts_ok_o asserts.
module uart_flow_ctrl_debounce #(
    parameter int unsigned CtsStableCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cts_i,
    output logic cts_ok_o
);

    localparam int unsigned CntW = $clog2(CtsStableCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CtsStableCycles);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Count consecutive high cycles, saturate, clear on any low cycle.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
        cnt_d = '0;
        if (cts_i) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gating with the live cts_i makes a CTS drop win over a same-cycle request.
    assign cts_ok_o = cts_i && (cnt_q == CntMax);

endmodule

// File: rtl/uart_flow_ctrl.sv
// 16750-style auto-RTS / auto-CTS sequencer between the modem block and the
// TX/RX engines. Transparent (software RTS, no TX stall) when afe_en_i is low.
module uart_flow_ctrl
    import uart_flow_ctrl_pkg::*;
#(
    parameter int unsigned FifoDepth       = 16,
    parameter int unsigned CtsStableCycles = 4,
    parameter int unsigned RtsLowWater     = 0,
    localparam int unsigned LvlW           = $clog2(FifoDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            afe_en_i,
    input  logic            rts_sw_i,
    input  logic            cts_i,
    input  logic [LvlW-1:0] rx_level_i,
    input  logic [1:0]      rx_trig_sel_i,
    uart_flow_ctrl_if.slave tx_if,
    output logic            rts_o
);

    localparam logic [LvlW-1:0] LvlFull = LvlW'(FifoDepth);
    localparam logic [LvlW-1:0] LvlLow  = LvlW'(RtsLowWater);

    flow_state_e     state_q, state_d;
    logic            cts_ok;
    logic            busy_prev_q;
    logic            busy_seen_q, busy_seen_d;
    logic            busy_age_q, busy_age_d;
    logic            busy_fall, busy_timeout;
    logic            rts_hold_q, rts_hold_d;
    logic            rts_q, rts_d;
    logic [LvlW-1:0] trig_lvl;
    logic            hold_set, hold_clr;

    uart_flow_ctrl_debounce #(
        .CtsStableCycles(CtsStableCycles)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .cts_i   (cts_i),
        .cts_ok_o(cts_ok)
    );

    // A frame ends on a busy falling edge, or if busy never showed up within two BUSY cycles.
    assign busy_fall    = busy_seen_q & busy_prev_q & ~tx_if.tx_busy;
    assign busy_timeout = busy_age_q & ~busy_seen_q & ~tx_if.tx_busy;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; afe_en_i is only consulted before a grant, so toggling it mid-frame affects the next frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tx_if.tx_req) begin
                    state_d = (!afe_en_i || cts_ok) ? GRANT : WAIT_CTS;
                end
            end
            WAIT_CTS: begin
                if (!tx_if.tx_req) begin
                    state_d = IDLE;
                end else if (cts_ok || !afe_en_i) begin
                    state_d = GRANT;
                end
            end
            GRANT: state_d = BUSY;
            BUSY: begin
                if (busy_fall || busy_timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        tx_if.tx_gnt    = (state_q == GRANT);
        tx_if.cts_stall = (state_q == WAIT_CTS);
    end

    // Frame tracking: whether busy has been seen since the grant and whether the first BUSY cycle has passed.
    always_comb begin
        busy_seen_d = 1'b0;
        busy_age_d  = 1'b0;
        if (state_q == BUSY) begin
            busy_seen_d = busy_seen_q | tx_if.tx_busy;
            busy_age_d  = 1'b1;
        end
    end

    // Frame tracking registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_prev_q <= 1'b0;
            busy_seen_q <= 1'b0;
            busy_age_q  <= 1'b0;
        end else begin
            busy_prev_q <= tx_if.tx_busy;
            busy_seen_q <= busy_seen_d;
            busy_age_q  <= busy_age_d;
        end
    end

    // RTS hysteresis: drop at the trigger level (or full), re-raise at the low-water mark.
    assign trig_lvl = LvlW'(trig_level(rx_trig_sel_i));
    assign hold_set = (rx_level_i >= trig_lvl) || (rx_level_i == LvlFull);
    assign hold_clr = (rx_level_i <= LvlLow);

    always_comb begin
        rts_hold_d = rts_hold_q;
        if (!afe_en_i) begin
            rts_hold_d = 1'b0;
        end else if (hold_set) begin
            rts_hold_d = 1'b1;
        end else if (hold_clr) begin
            rts_hold_d = 1'b0;
        end
        rts_d = rts_sw_i & ~rts_hold_d;
    end

    // RTS registers; rts_o is always one cycle behind its inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rts_hold_q <= 1'b0;
            rts_q      <= 1'b0;
        end else begin
            rts_hold_q <= rts_hold_d;
            rts_q      <= rts_d;
        end
    end

    assign rts_o = rts_q;

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// Self-checking bench for uart_flow_ctrl: directed corner sequences, an RTS
// threshold vector table, and a randomized run against a behavioural model.
module tb_uart_flow_ctrl;

    localparam int FifoDepth = 16;
    localparam int StableN   = 4;
    localparam int LvlW      = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            afe_en_i;
    logic            rts_sw_i;
    logic            cts_i;
    logic [LvlW-1:0] rx_level_i;
    logic [1:0]      rx_trig_sel_i;
    logic            rts_o;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_flow_ctrl_if tx_if ();

    uart_flow_ctrl #(
        .FifoDepth      (FifoDepth),
        .CtsStableCycles(StableN),
        .RtsLowWater    (0)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .afe_en_i     (afe_en_i),
        .rts_sw_i     (rts_sw_i),
        .cts_i        (cts_i),
        .rx_level_i   (rx_level_i),
        .rx_trig_sel_i(rx_trig_sel_i),
        .tx_if        (tx_if),
        .rts_o        (rts_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       afe;
        logic       sw;
        logic [1:0] sel;
        logic [4:0] lvl;
        logic       exp_rts;
    } rts_vec_t;

    rts_vec_t vecs[$];
    int       trig_tab [4] = '{1, 4, 8, 14};

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then stable for the new cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_gnt(input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step();
            if (tx_if.tx_gnt === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        afe_en_i      = 1'b0;
        rts_sw_i      = 1'b0;
        cts_i         = 1'b0;
        rx_level_i    = '0;
        rx_trig_sel_i = 2'd0;
        tx_if.tx_req  = 1'b0;
        tx_if.tx_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        logic pat [8];

        // ---------------- reset state ----------------
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        check("rst_gnt", tx_if.tx_gnt, 0);
        check("rst_stall", tx_if.cts_stall, 0);
        check("rst_rts", rts_o, 0);
        do_reset();

        // ---------------- 1: transparent mode ----------------
        rts_sw_i     = 1'b1;
        tx_if.tx_req = 1'b1;
        step();
        check("t1_rts", rts_o, 1);
        check("t1_gnt", tx_if.tx_gnt, 1);
        check("t1_stall", tx_if.cts_stall, 0);
        tx_if.tx_req = 1'b0;
        step();
        check("t1_gnt_pulse", tx_if.tx_gnt, 0);
        check("t1_stall2", tx_if.cts_stall, 0);
        repeat (4) step();

        // ---------------- 2: stall until CTS debounced ----------------
        afe_en_i     = 1'b1;
        tx_if.tx_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_stall", tx_if.cts_stall, 1);
            check("t2_no_gnt", tx_if.tx_gnt, 0);
        end
        cts_i = 1'b1;
        wait_gnt(20, n);
        check("t2_gnt_latency", n, 5);
        tx_if.tx_req = 1'b0;
        repeat (4) step();

        // ---------------- 3: CTS glitch restarts debounce ----------------
        cts_i        = 1'b0;
        tx_if.tx_req = 1'b1;
        step();
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            cts_i = pat[k];
            step();
            check("t3_no_early_gnt", tx_if.tx_gnt, 0);
        end
        cts_i = 1'b1;
        step();
        check("t3_gnt", tx_if.tx_gnt, 1);

        // ---------------- 4: CTS drop mid-frame does not abort ----------------
        afe_en_i      = 1'b1;
        rts_sw_i      = 1'b1;
        rx_level_i    = 5'd16;
        for (int k = 0; k < 10; k++) begin
            step();
            tx_if.tx_busy = 1'b1;
            if (k == 3) cts_i = 1'b0;
            check("t4_busy_no_gnt", tx_if.tx_gnt, 0);
            check("t4_busy_no_stall", tx_if.cts_stall, 0);
        end
        step();
        tx_if.tx_busy = 1'b0;
        step();
        step();
        check("t4_wait_cts", tx_if.cts_stall, 1);
        check("t4_no_gnt", tx_if.tx_gnt, 0);
        check("t4_rts_full", rts_o, 0);
        cts_i = 1'b1;
        wait_gnt(20, n);
        check("t4_regnt_latency", n, 5);

        // ---------------- 6: async reset mid-grant ----------------
        rst_ni = 1'b0;
        #1;
        check("t6_rst_gnt", tx_if.tx_gnt, 0);
        check("t6_rst_stall", tx_if.cts_stall, 0);
        check("t6_rst_rts", rts_o, 0);
        step();
        rst_ni = 1'b1;
        wait_gnt(20, n);
        check("t6_post_rst_latency", n, 5);
        check("t6_rts_still_held", rts_o, 0);
        tx_if.tx_req = 1'b0;
        repeat (4) step();

        // ---------------- 5: RTS threshold table ----------------
        do_reset();
        for (int l = 0; l <= 8; l++) vecs.push_back('{1'b1, 1'b1, 2'd2, 5'(l), (l == 8) ? 1'b0 : 1'b1});
        for (int l = 7; l >= 1; l--) vecs.push_back('{1'b1, 1'b1, 2'd2, 5'(l), 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 5'd0,  1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 5'd1,  1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 5'd0,  1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 5'd13, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 5'd14, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 5'd5,  1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 5'd5,  1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 5'd0,  1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 5'd16, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd1, 5'd16, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 5'd16, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'd3, 5'd0,  1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 5'd0,  1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 5'd7,  1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 5'd7,  1'b0});
        foreach (vecs[i]) begin
            afe_en_i      = vecs[i].afe;
            rts_sw_i      = vecs[i].sw;
            rx_trig_sel_i = vecs[i].sel;
            rx_level_i    = vecs[i].lvl;
            step();
            check($sformatf("t5_vec%0d_rts", i), rts_o, vecs[i].exp_rts);
        end

        // ---------------- randomized run vs behavioural model ----------------
        begin
            int run_len   = 0;      // consecutive CTS-high cycles including the current one
            bit hold_m    = 1'b0;
            int ready_at  = 0;      // first cycle the sequencer can accept a new request
            bit e_gnt     = 1'b0;
            bit e_stall   = 1'b0;
            bit e_rts     = 1'b0;
            int busy_left = 0;
            int lvl_m     = 0;
            int flen      = 0;
            bit ready, cond;

            do_reset();
            for (int t = 0; t < 3000; t++) begin
                check("rnd_gnt", tx_if.tx_gnt, e_gnt);
                check("rnd_stall", tx_if.cts_stall, e_stall);
                check("rnd_rts", rts_o, e_rts);

                if ($urandom_range(0, 7) == 0)  cts_i = ~cts_i;
                if ($urandom_range(0, 63) == 0) afe_en_i = ~afe_en_i;
                if ($urandom_range(0, 15) == 0) rts_sw_i = ~rts_sw_i;
                if ($urandom_range(0, 31) == 0) rx_trig_sel_i = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0: if (lvl_m < FifoDepth) lvl_m++;
                    1: if (lvl_m > 0) lvl_m--;
                    2: lvl_m = $urandom_range(0, FifoDepth);
                    default: ;
                endcase
                rx_level_i = 5'(lvl_m);
                if ($urandom_range(0, 5) == 0) tx_if.tx_req = ~tx_if.tx_req;

                // TX engine: busy for flen cycles starting the cycle after a grant.
                tx_if.tx_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
                if (e_gnt || tx_if.tx_gnt) begin
                    flen         = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
                    busy_left    = flen;
                    tx_if.tx_req = 1'b0;
                end
                if (e_gnt) ready_at = t + ((flen == 0) ? 3 : flen + 2);

                ready   = (t >= ready_at) && !e_gnt;
                run_len = cts_i ? run_len + 1 : 0;
                cond    = !afe_en_i || (run_len >= StableN + 1);
                e_gnt   = ready && tx_if.tx_req && cond;
                e_stall = ready && tx_if.tx_req && !cond;

                if (!afe_en_i)                              hold_m = 1'b0;
                else if (lvl_m >= trig_tab[rx_trig_sel_i])  hold_m = 1'b1;
                else if (lvl_m == 0)                        hold_m = 1'b0;
                e_rts = rts_sw_i && !hold_m;

                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_flow_ctrl.md
Name: uart_flow_ctrl

Overview:
Hardware auto flow control sequencer for the UART, 16750-style auto-RTS/auto-CTS.
- Sits between the modem block (synchronised CTS in, RTS request out) and the TX/RX engines.
- Gates start of every TX frame on a stable CTS.
- Drops RTS when the RX FIFO reaches the trigger level; re-raises it when the FIFO drains.
- When auto-flow is disabled, it is transparent: software RTS only, TX never stalled.

Parameters:
FifoDepth, 16, RX FIFO depth; level width LvlW = $clog2(FifoDepth+1).
CtsStableCycles, 4, consecutive cycles CTS must be asserted before a TX grant (debounce). Must be >= 1.
RtsLowWater, 0, RX level at or below which RTS is re-asserted after a drop. Must be < smallest trigger level.

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
afe_en_i  in  1  auto flow enable (MCR.afe)
rts_sw_i  in  1  software RTS request (MCR.rts), active-high
cts_i  in  1  synchronised CTS, active-high (already inverted, already 2-stage synced)
rx_level_i  in  LvlW  current RX FIFO fill level
rx_trig_sel_i  in  2  FCR trigger select: 0→1, 1→4, 2→8, 3→14 entries
tx_req_i  in  1  TX engine has a byte ready to start a frame
tx_gnt_o  out  1  one-cycle pulse: TX may start the frame now
tx_busy_i  in  1  TX shifting a frame (start bit through stop bits)
rts_o  out  1  RTS to modem output, active-high (modem drives rts_n = ~rts_o)
cts_stall_o  out  1  TX request pending and blocked by CTS (status/IRQ source)

Behaviour:
Reset values:
- tx_gnt_o=0, rts_o=0, cts_stall_o=0.
- TX FSM in IDLE; debounce counter 0; rts_hold=0.
- Mid-operation reset aborts any grant; no pulse is emitted after reset release until the first full debounce.

CTS debounce:
- cnt increments while cts_i=1, saturating at CtsStableCycles.
- cnt clears to 0 on any cycle with cts_i=0.
- cts_ok = (cnt == CtsStableCycles).

TX FSM (IDLE, WAIT_CTS, GRANT, BUSY):
- IDLE: on tx_req_i → GRANT if (!afe_en_i || cts_ok), else → WAIT_CTS.
- WAIT_CTS: cts_stall_o=1. → GRANT when cts_ok or afe_en_i falls. → IDLE if tx_req_i drops.
- GRANT: tx_gnt_o=1 for exactly one cycle; → BUSY.
- BUSY: wait for tx_busy_i falling edge (registered previous value); → IDLE.
- BUSY safety: if tx_busy_i was never seen high for 2 cycles after the grant, → IDLE.
- CTS dropping during BUSY does NOT abort the frame; it only blocks the next grant.
- Grant latency: tx_req_i in cycle N with cts_ok → tx_gnt_o in cycle N+1.

RTS:
- afe_en_i=0: rts_o = rts_sw_i, registered (1 cycle latency); rts_hold cleared.
- afe_en_i=1: rts_o = rts_sw_i & ~rts_hold.
  - rts_hold sets when rx_level_i >= trig(rx_trig_sel_i).
  - rts_hold clears when rx_level_i <= RtsLowWater.
  - Between these thresholds rts_hold keeps its value (hysteresis).
- Set and clear conditions are mutually exclusive given the parameter constraint.
- rx_trig_sel_i change takes effect the next cycle; level compare is unsigned, LvlW bits.
- rx_level_i == FifoDepth (full) always sets rts_hold.

Simultaneous events:
- tx_req_i and a CTS drop in the same cycle: the drop wins (cnt cleared, go to WAIT_CTS).
- afe_en_i toggled mid-BUSY: takes effect for the next frame only.

Decomposition:
- uart_pkg gains:
  - flow_state_e (IDLE, WAIT_CTS, GRANT, BUSY);
  - localparam array RxTrigLevels = {1,4,8,14};
  - function trig_level(sel) returning LvlW-wide value.
- One natural sub-module: uart_flow_debounce (saturating stable-high counter, cnt/cts_ok).
- Registers use the common `FF macros with async active-low reset.

Test Plan:
1. afe_en=0, rts_sw=1, cts_i=0, tx_req=1 → rts_o=1 next cycle; tx_gnt_o pulses 1 cycle after req; cts_stall_o stays 0.
2. afe_en=1, cts_i=0, tx_req=1 for 10 cycles, then cts_i=1 → cts_stall_o=1 throughout the wait; tx_gnt_o pulses exactly 5 cycles after cts rises (4 debounce + 1).
3. cts_i glitch 1,1,1,0,1,1,1,1 with tx_req held → no grant before the fourth consecutive high; single pulse afterward.
4. Grant issued, tx_busy 10 cycles, cts_i drops at busy cycle 3 → frame runs to completion; no new grant until cts stable 4 cycles; FSM in WAIT_CTS if tx_req remains.
5. afe_en=1, trig_sel=2, rts_sw=1, rx_level ramps 0..8 → rts_o falls in the cycle after level=8; level 7..1 keeps rts_o=0; level 0 → rts_o=1 next cycle.
6. rst_ni asserted while in GRANT/BUSY with rts_hold=1 → all outputs 0 immediately (async); after release a grant requires a full 4-cycle CTS debounce.
